one_result_collector: RTL and testbench

//   Consumer-side companion to the 2-stage `one` adder pipeline.
//   - Tracks which pipeline slots carry a real operation, using a valid shift register.
//   - Captures pipe_out when a tracked result lands and buffers it in a FIFO.
//   - Presents buffered results on a valid/ready stream.
//   - Issues credits so the producer never overruns the buffer.
//   - The pipeline has no stall or reset, so this block supplies flow control.

---
 rtl/one_result_collector.sv | 96 +++++++++
 tb/tb_one_result_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/one_result_collector.sv
// Result collector for the latency-LATENCY `one` adder pipeline: tracks real
// operations, buffers their results in a FIFO and issues producer credits.
module one_result_collector #(
    parameter int W       = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic                       credit_ok,
    input  logic [W-1:0]               pipe_out,
    output logic [W-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [LATENCY-1:0] vld;
    logic [W-1:0]       mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      inflight;
    logic               accept;
    logic               push;
    logic               pop;

    // Every tracked slot is already reserved against the FIFO, so credit
    // counts both the pipeline contents and the buffered results.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(vld[i]);
        end
    end

    assign occupancy = inflight + count;
    assign credit_ok = (occupancy < CW'(DEPTH));
    assign accept    = issue & credit_ok;
    assign push      = vld[LATENCY-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end

            if (issue && !credit_ok) begin
                overflow <= 1'b1;
            end

            // DEPTH is a power of two, so pointer wrap is the natural rollover.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read once
    // count says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pipe_out;
        end
    end

    // Credit accounting guarantees a landing result always finds a free slot.
    assert property (@(posedge clk) disable iff (rst) push |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_one_result_collector.sv
// Self-checking bench: a stub adder pipeline feeds the collector and a
// queue-based model of issue order, credit and buffering predicts every output.
module tb_one_result_collector;

    localparam int W       = 32;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          issue;
    logic          credit_ok;
    logic [W-1:0]  x, y;
    logic [W-1:0]  pipe_out;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] occupancy;
    logic          overflow;

    logic [W-1:0]  pipe [LATENCY];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: in-flight ops (due cycle, value), FIFO contents.
    int           due_q [$];
    logic [W-1:0] val_q [$];
    logic [W-1:0] fifo_q [$];
    logic         m_overflow = 1'b0;

    always #5 clk = ~clk;

    one_result_collector #(.W(W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .credit_ok (credit_ok),
        .pipe_out  (pipe_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    // Stub of the `one` pipeline: no reset, no stall, sums every cycle.
    always_ff @(posedge clk) begin
        pipe[0] <= x + y;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign pipe_out = pipe[LATENCY-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int m_occ();
        return due_q.size() + fifo_q.size();
    endfunction

    function automatic logic m_credit();
        return m_occ() < DEPTH;
    endfunction

    // One clock cycle: compare outputs with the model, apply inputs, advance.
    task automatic step(input logic i_issue, input logic [W-1:0] ix, input logic [W-1:0] iy,
                        input logic ready, input logic r);
        logic acc;
        issue = i_issue; x = ix; y = iy; out_ready = ready; rst = r;
        #1;
        check("occupancy", 64'(occupancy), 64'(m_occ()));
        check("credit_ok", 64'(credit_ok), 64'(m_credit()));
        check("out_valid", 64'(out_valid), 64'(fifo_q.size() != 0));
        check("overflow",  64'(overflow),  64'(m_overflow));
        if (fifo_q.size() != 0) check("out_data", 64'(out_data), 64'(fifo_q[0]));
        if (occupancy > CW'(DEPTH)) check("occ_bound", 64'(occupancy), 64'(DEPTH));

        acc = i_issue && m_credit();
        if (r) begin
            due_q.delete(); val_q.delete(); fifo_q.delete();
            m_overflow = 1'b0;
        end else begin
            if (fifo_q.size() != 0 && ready) void'(fifo_q.pop_front());
            if (due_q.size() != 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                fifo_q.push_back(val_q.pop_front());
            end
            if (acc) begin
                due_q.push_back(cyc + LATENCY);
                val_q.push_back(ix + iy);
            end
            if (i_issue && !acc) m_overflow = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, ready, 1'b0);
    endtask

    initial begin
        int accepted;
        int budget;

        rst = 1'b1; issue = 1'b0; x = '0; y = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 0, 0, 1'b0, 1'b1);

        // T1: single op, result visible exactly in issue cycle + 3.
        step(1'b1, 3, 5, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) check("t1_data", 64'(out_data), 64'd8);
            check("t1_valid", 64'(out_valid), 64'(k == 3));
            step(1'b0, $urandom, $urandom, 1'b1, 1'b0);
        end
        check("t1_occ", 64'(occupancy), 64'd0);

        // T2: back-to-back issue, results drained in order.
        for (int i = 0; i < 8; i++) step(1'b1, W'(i), 100, 1'b1, 1'b0);
        idle(6, 1'b1);
        check("t2_overflow", 64'(overflow), 64'd0);

        // T3: backpressure until full.
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_credit()) accepted++;
            step(m_credit(), $urandom, $urandom, 1'b0, 1'b0);
        end
        check("t3_accepted", 64'(accepted), 64'(DEPTH));
        check("t3_full_occ", 64'(occupancy), 64'(DEPTH));
        check("t3_no_credit", 64'(credit_ok), 64'd0);

        // T4: forced issue while full sets the sticky overflow.
        step(1'b1, 7, 7, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_occ", 64'(occupancy), 64'(DEPTH));

        // Drain: credit returns the cycle after the first pop.
        step(1'b0, 0, 0, 1'b1, 1'b0);
        check("t3_credit_back", 64'(credit_ok), 64'd1);
        idle(6, 1'b1);
        check("t4_no_fifth", 64'(out_valid), 64'd0);
        check("t4_sticky", 64'(overflow), 64'd1);

        // T5: reset one cycle after the second issue drops everything.
        step(1'b1, 1, 2, 1'b1, 1'b0);
        step(1'b1, 3, 4, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t5_quiet", 64'(out_valid), 64'd0);
            step(1'b0, $urandom, $urandom, 1'b1, 1'b0);
        end
        check("t5_occ", 64'(occupancy), 64'd0);
        check("t5_credit", 64'(credit_ok), 64'd1);
        check("t5_overflow", 64'(overflow), 64'd0);

        // T6: random traffic with 50% ready, exercising pointer wrap.
        accepted = 0;
        budget   = 0;
        while (accepted < 200 && budget < 5000) begin
            logic want;
            want = $urandom_range(0, 3) != 0;
            if (want && m_credit()) accepted++;
            step(want && m_credit(), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        check("t6_budget", 64'(accepted), 64'd200);
        budget = 0;
        while (m_occ() != 0 && budget < 100) begin
            step(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        check("t6_drained", 64'(occupancy), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
